// File: rtl/ir_fetch_sequencer.sv
// ir_fetch_sequencer: control FSM for the PDUA core's instruction fetch path.
// For each instruction it moves PC into MAR, handshakes the memory read and
// loads the IR. It then decodes the opcode and steps a micro-step counter
// through the execute phase. A read that never completes clears the IR to a
// NOP and sets a sticky fault flag.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-low reset
//   start      in   leave IDLE / resume from HALT
//   opcode     in   IR[7:3] opcode field
//   mem_ack    in   memory read data valid this cycle
//   stall      in   datapath stall, freezes EXEC
//   pc_to_mar  out  load MAR from PC
//   mem_rd     out  memory read request (level)
//   ir_ena     out  IR load enable
//   ir_sclr    out  IR synchronous clear (always paired with ir_ena)
//   pc_inc     out  increment PC
//   exec_valid out  micro-step upc is active this cycle
//   upc        out  current micro-step index
//   halted     out  sequencer is in HALT
//   fault      out  sticky fetch-timeout flag
module ir_fetch_sequencer #(
    parameter int unsigned             OPCODE_WIDTH = 5,
    parameter logic [OPCODE_WIDTH-1:0] HALT_OPCODE  = '1,
    parameter int unsigned             TIMEOUT      = 15,
    parameter int unsigned             UPC_WIDTH    = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [OPCODE_WIDTH-1:0] opcode,
    input  logic                    mem_ack,
    input  logic                    stall,
    output logic                    pc_to_mar,
    output logic                    mem_rd,
    output logic                    ir_ena,
    output logic                    ir_sclr,
    output logic                    pc_inc,
    output logic                    exec_valid,
    output logic [UPC_WIDTH-1:0]    upc,
    output logic                    halted,
    output logic                    fault
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH_ADDR,
        FETCH_WAIT,
        LOAD_IR,
        FAULT_CLR,
        DECODE,
        EXEC,
        HALT
    } state_t;

    state_t               state, state_next;
    logic [UPC_WIDTH-1:0] upc_q, upc_next;
    logic [UPC_WIDTH-1:0] last_step, last_step_next;
    logic [7:0]           wait_cnt, wait_cnt_next;
    logic                 fault_q, fault_next;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            upc_q     <= '0;
            last_step <= '0;
            wait_cnt  <= '0;
            fault_q   <= 1'b0;
        end else begin
            state     <= state_next;
            upc_q     <= upc_next;
            last_step <= last_step_next;
            wait_cnt  <= wait_cnt_next;
            fault_q   <= fault_next;
        end
    end

    always_comb begin
        state_next     = state;
        upc_next       = upc_q;
        last_step_next = last_step;
        wait_cnt_next  = wait_cnt;
        fault_next     = fault_q;
        pc_to_mar      = 1'b0;
        mem_rd         = 1'b0;
        ir_ena         = 1'b0;
        ir_sclr        = 1'b0;
        pc_inc         = 1'b0;
        exec_valid     = 1'b0;
        halted         = 1'b0;

        case (state)
            IDLE: begin
                if (start) state_next = FETCH_ADDR;
            end
            FETCH_ADDR: begin
                pc_to_mar     = 1'b1;
                wait_cnt_next = '0;
                state_next    = FETCH_WAIT;
            end
            FETCH_WAIT: begin
                mem_rd = 1'b1;
                // The counter holds the number of ack-less cycles already
                // spent, so the TIMEOUT-th wait cycle sees TIMEOUT-1 here;
                // an ack in that same cycle still takes priority.
                if (mem_ack) begin
                    state_next = LOAD_IR;
                end else if (wait_cnt == 8'(TIMEOUT - 1)) begin
                    state_next = FAULT_CLR;
                end else begin
                    wait_cnt_next = wait_cnt + 8'd1;
                end
            end
            LOAD_IR: begin
                ir_ena     = 1'b1;
                pc_inc     = 1'b1;
                state_next = DECODE;
            end
            FAULT_CLR: begin
                ir_ena     = 1'b1;
                ir_sclr    = 1'b1;
                fault_next = 1'b1;
                state_next = DECODE;
            end
            DECODE: begin
                if (opcode == HALT_OPCODE) begin
                    state_next = HALT;
                end else begin
                    last_step_next = UPC_WIDTH'(opcode[1:0]);
                    upc_next       = '0;
                    state_next     = EXEC;
                end
            end
            EXEC: begin
                exec_valid = ~stall;
                if (!stall) begin
                    if (upc_q == last_step) begin
                        upc_next   = '0;
                        state_next = FETCH_ADDR;
                    end else begin
                        upc_next = upc_q + UPC_WIDTH'(1);
                    end
                end
            end
            HALT: begin
                halted = 1'b1;
                if (start) state_next = FETCH_ADDR;
            end
            default: state_next = IDLE;
        endcase
    end

    assign upc   = upc_q;
    assign fault = fault_q;

endmodule

// File: tb/tb_ir_fetch_sequencer.sv
// Testbench for ir_fetch_sequencer. The stimulus process drives one cycle of
// inputs and queues the hand-computed output vector for that cycle. A
// separate monitor pops and compares that vector on the falling edge.
// Vector bit order: pc_to_mar, mem_rd, ir_ena, ir_sclr, pc_inc, exec_valid,
// upc[1:0], halted, fault.
module tb_ir_fetch_sequencer;

    logic       clk = 1'b0;
    logic       rst, start, mem_ack, stall;
    logic [4:0] opcode;
    logic       pc_to_mar, mem_rd, ir_ena, ir_sclr, pc_inc, exec_valid;
    logic [1:0] upc;
    logic       halted, fault;

    int unsigned checks   = 0;
    int unsigned failures = 0;
    logic        fb       = 1'b0;

    logic [9:0] exp_q[$];
    string      nm_q[$];

    localparam logic [9:0] E_ID = 10'b00_0000_0000;
    localparam logic [9:0] E_FA = 10'b10_0000_0000;
    localparam logic [9:0] E_FW = 10'b01_0000_0000;
    localparam logic [9:0] E_LD = 10'b00_1010_0000;
    localparam logic [9:0] E_FC = 10'b00_1100_0000;
    localparam logic [9:0] E_HT = 10'b00_0000_0010;

    ir_fetch_sequencer #(
        .OPCODE_WIDTH(5),
        .HALT_OPCODE (5'b11111),
        .TIMEOUT     (15),
        .UPC_WIDTH   (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .opcode    (opcode),
        .mem_ack   (mem_ack),
        .stall     (stall),
        .pc_to_mar (pc_to_mar),
        .mem_rd    (mem_rd),
        .ir_ena    (ir_ena),
        .ir_sclr   (ir_sclr),
        .pc_inc    (pc_inc),
        .exec_valid(exec_valid),
        .upc       (upc),
        .halted    (halted),
        .fault     (fault)
    );

    always #5 clk = ~clk;

    function automatic logic [9:0] ex(input logic [1:0] u);
        return 10'b00_0001_0000 | {6'b0, u, 2'b0};
    endfunction

    task automatic cyc(input logic r, input logic s, input logic [4:0] op,
                       input logic a, input logic st, input logic [9:0] e,
                       input string nm);
        @(posedge clk);
        #1;
        rst     = r;
        start   = s;
        opcode  = op;
        mem_ack = a;
        stall   = st;
        exp_q.push_back(e | {9'b0, fb});
        nm_q.push_back(nm);
    endtask

    // Monitor
    initial begin
        logic [9:0] act, e;
        string      nm;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                nm  = nm_q.pop_front();
                act = {pc_to_mar, mem_rd, ir_ena, ir_sclr, pc_inc,
                       exec_valid, upc, halted, fault};
                checks++;
                if (act !== e) begin
                    failures++;
                    $display("FAIL %s: got %b expected %b", nm, act, e);
                end
            end
        end
    end

    // Stimulus
    initial begin
        rst = 1'b0; start = 1'b1; opcode = '0; mem_ack = 1'b0; stall = 1'b0;

        // reset held with start high, then released: stays idle
        cyc(0, 1, 0, 0, 0, E_ID, "rst_hold");
        cyc(0, 1, 0, 0, 0, E_ID, "rst_hold");
        cyc(1, 0, 0, 0, 0, E_ID, "rst_rel");
        repeat (4) cyc(1, 0, 0, 0, 0, E_ID, "idle_stay");

        // basic fetch, opcode 00011 -> 4 steps; stray stall/start/ack ignored
        cyc(1, 1, 3, 0, 0, E_ID, "idle_start");
        cyc(1, 0, 3, 0, 0, E_FA, "b_fa");
        cyc(1, 0, 3, 1, 1, E_FW, "b_fw");
        cyc(1, 0, 3, 0, 0, E_LD, "b_ld");
        cyc(1, 0, 3, 0, 0, E_ID, "b_dec");
        for (int u = 0; u < 4; u++) cyc(1, 1, 3, 1, 0, ex(2'(u)), "b_ex");
        cyc(1, 0, 9, 0, 0, E_FA, "b_fa2");

        // stall: opcode 01001 -> 2 steps, 3 stalled cycles at upc 0
        cyc(1, 0, 9, 1, 0, E_FW, "s_fw");
        cyc(1, 0, 9, 0, 0, E_LD, "s_ld");
        cyc(1, 0, 9, 0, 1, E_ID, "s_dec");
        repeat (3) cyc(1, 0, 9, 0, 1, E_ID, "s_stall");
        cyc(1, 0, 9, 0, 0, ex(2'd0), "s_ex0");
        cyc(1, 0, 9, 0, 0, ex(2'd1), "s_ex1");
        cyc(1, 0, 0, 0, 0, E_FA, "s_fa");

        // ack on the 15th wait cycle wins over the timeout
        repeat (14) cyc(1, 0, 0, 0, 0, E_FW, "k_fw");
        cyc(1, 0, 0, 1, 0, E_FW, "k_fw15");
        cyc(1, 0, 0, 0, 0, E_LD, "k_ld");
        cyc(1, 0, 0, 0, 0, E_ID, "k_dec");
        cyc(1, 0, 0, 0, 0, ex(2'd0), "k_ex0");
        cyc(1, 0, 0, 0, 0, E_FA, "k_fa");

        // timeout: 15 wait cycles, IR clear, NOP, sticky fault
        repeat (15) cyc(1, 0, 0, 0, 0, E_FW, "t_fw");
        cyc(1, 0, 0, 0, 0, E_FC, "t_fc");
        fb = 1'b1;
        cyc(1, 0, 0, 0, 0, E_ID, "t_dec");
        cyc(1, 0, 0, 0, 0, ex(2'd0), "t_nop");
        cyc(1, 0, 31, 0, 0, E_FA, "t_fa");

        // halt and resume
        cyc(1, 0, 31, 1, 0, E_FW, "h_fw");
        cyc(1, 0, 31, 0, 0, E_LD, "h_ld");
        cyc(1, 0, 31, 0, 0, E_ID, "h_dec");
        repeat (3) cyc(1, 0, 31, 1, 1, E_HT, "h_halt");
        cyc(1, 1, 31, 0, 0, E_HT, "h_start");
        cyc(1, 0, 3, 0, 0, E_FA, "h_fa");

        // reset during EXEC at upc 2
        cyc(1, 0, 3, 1, 0, E_FW, "r_fw");
        cyc(1, 0, 3, 0, 0, E_LD, "r_ld");
        cyc(1, 0, 3, 0, 0, E_ID, "r_dec");
        cyc(1, 0, 3, 0, 0, ex(2'd0), "r_ex0");
        cyc(1, 0, 3, 0, 0, ex(2'd1), "r_ex1");
        cyc(0, 0, 3, 0, 0, ex(2'd2), "r_ex2");
        fb = 1'b0;
        cyc(1, 0, 3, 0, 0, E_ID, "r_idle");
        cyc(1, 0, 3, 0, 0, E_ID, "r_idle2");

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/ir_fetch_sequencer.md
Name: ir_fetch_sequencer

Overview:
- Control FSM that sequences the instruction register (IR) and the fetch path of the PDUA core.
- Per instruction: drives PC onto MAR, handshakes the memory read, loads the IR, decodes the 5-bit opcode and steps a micro-step counter through the execute phase.
- Handles HALT, datapath stalls, and memory-read timeout. On timeout it clears the IR to a NOP using ir_sclr.

Parameters:
- OPCODE_WIDTH, 5, width of opcode input taken from IR[7:3].
- HALT_OPCODE, 5'b11111, opcode that stops the sequencer.
- TIMEOUT, 15, maximum FETCH_WAIT cycles without mem_ack before a fault (1..255).
- UPC_WIDTH, 2, micro-step counter width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, synchronous, active-low.
- start  in  1  leaves IDLE, or resumes from HALT.
- opcode  in  OPCODE_WIDTH  current IR opcode field.
- mem_ack  in  1  memory read data valid on busC this cycle.
- stall  in  1  datapath stall; freezes EXEC.
- pc_to_mar  out  1  load MAR from PC.
- mem_rd  out  1  memory read request.
- ir_ena  out  1  IR load enable.
- ir_sclr  out  1  IR synchronous clear; only ever asserted together with ir_ena.
- pc_inc  out  1  increment PC.
- exec_valid  out  1  micro-step upc is active this cycle.
- upc  out  UPC_WIDTH  current execute micro-step index.
- halted  out  1  sequencer is in HALT.
- fault  out  1  sticky: a fetch timed out.

Behaviour:
- Reset:
  - rst=0 sampled at a rising clk edge forces state=IDLE, upc=0, last_step=0, timeout counter=0, fault=0.
  - All outputs are decoded from registered state, so every output is 0 in the cycle after the reset edge.
  - Reset mid-fetch or mid-exec abandons the operation with no further strobes.
- All strobes are single-cycle Moore outputs of the state, except mem_rd (level) and exec_valid (qualified by stall).
- States and transitions:
  - IDLE: all outputs 0. start=1 -> FETCH_ADDR.
  - FETCH_ADDR: pc_to_mar=1 -> FETCH_WAIT. Timeout counter cleared.
  - FETCH_WAIT: mem_rd=1.
    - mem_ack=1 -> LOAD_IR.
    - Otherwise the counter increments; when the counter reaches TIMEOUT with no ack -> FAULT_CLR.
    - An ack in the same cycle the counter reaches TIMEOUT wins: go to LOAD_IR, no fault.
  - LOAD_IR: ir_ena=1, pc_inc=1 -> DECODE.
  - FAULT_CLR: ir_ena=1, ir_sclr=1, pc_inc=0. fault<=1 (sticky until reset) -> DECODE. The IR now holds opcode 0, which executes as a one-step NOP.
  - DECODE: opcode is valid here because the IR updated at the previous edge.
    - opcode==HALT_OPCODE -> HALT.
    - Otherwise last_step<=opcode[1:0], upc<=0 -> EXEC.
  - EXEC: exec_valid = ~stall.
    - stall=1: upc holds and state holds.
    - stall=0 and upc==last_step -> FETCH_ADDR, upc<=0.
    - stall=0 otherwise: upc<=upc+1.
    - Execute length is opcode[1:0]+1 cycles (1..4), excluding stall cycles.
  - HALT: halted=1, other strobes 0. start=1 -> FETCH_ADDR (resume at next PC); otherwise stays.
- start is ignored outside IDLE and HALT.
- mem_ack outside FETCH_WAIT is ignored.
- stall outside EXEC is ignored.
- Instruction period with no wait and no stall: FETCH_ADDR + 1 FETCH_WAIT + LOAD_IR + DECODE + steps = 4 + (opcode[1:0]+1) cycles.
- upc never exceeds last_step. There is no wrap-around.

Test Plan:
- Reset/idle: hold rst=0 for 2 cycles with start=1 -> all outputs 0. Release rst with start=0 -> stays IDLE indefinitely.
- Basic fetch, opcode=5'b00011, mem_ack one cycle after mem_rd rises -> pc_to_mar, then mem_rd 1 cycle, then ir_ena+pc_inc, then DECODE, then exec_valid for 4 cycles with upc=0,1,2,3, then pc_to_mar again. Period = 8 cycles.
- Stall: opcode=5'b01001 (2 steps), stall=1 for 3 cycles at upc=0 -> upc holds 0 and exec_valid=0 for 3 cycles, then upc=0 valid, upc=1 valid, then FETCH_ADDR.
- Timeout, TIMEOUT=15, mem_ack never asserted -> mem_rd high 15 cycles, then one cycle with ir_ena=1, ir_sclr=1, pc_inc=0, then fault=1. Exactly 1 exec step (NOP) follows, then refetch. fault stays 1.
- Ack at boundary: mem_ack arrives on the 15th wait cycle -> LOAD_IR, fault stays 0.
- HALT: opcode=5'b11111 -> halted=1 from the cycle after DECODE with no exec_valid. start pulse -> pc_to_mar next cycle. Assert rst=0 during EXEC at upc=2 -> IDLE next cycle, upc=0, fault=0.
